// File: rtl/framebuffer_swapchain.sv
// Purpose: 2- or 3-buffer pixel swapchain between rasterizer writes and VGA scan-out, tear-free swaps on vsync.
// Latency: read 1 clk addrb->doutb; write at the sampling edge; disp_idx moves 3 clk after raw vsync falls.
// Backpressure: wr_ready drops after frame_done until the swap (2 buffers); always ready with 3 buffers.
module framebuffer_swapchain #(
  parameter int ADDR_WIDTH = 17,
  parameter int DEPTH      = 76800,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BUFS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  frame_done,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic [1:0]            disp_idx,
  output logic [CNT_WIDTH-1:0]  frames_dropped,
  output logic [CNT_WIDTH-1:0]  frames_repeated
);

  if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
    $error("framebuffer_swapchain: NUM_BUFS must be 2 or 3");
  end

  // All buffers share one flat array; buffer n occupies words [n*DEPTH, (n+1)*DEPTH).
  localparam int                  MEM_WORDS = NUM_BUFS * DEPTH;
  localparam int                  MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic       vs_sync1, vs_sync2, vs_prev;
  logic       swap_evt;
  logic [1:0] draw_idx, ready_idx, third_idx;
  logic       ready_valid, done_pend;
  logic       fd_in, done_any, do_done;
  logic       wr_en, rd_in_range;
  logic [MEM_AW-1:0] wr_lin, rd_lin;

  // Raw vsync comes from another clock domain: two sync flops, then a previous-value flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync1 <= 1'b1;
      vs_sync2 <= 1'b1;
      vs_prev  <= 1'b1;
    end else begin
      vs_sync1 <= vsync;
      vs_sync2 <= vs_sync1;
      vs_prev  <= vs_sync2;
    end
  end

  assign swap_evt  = vs_prev & ~vs_sync2;
  assign third_idx = 2'd3 - disp_idx - draw_idx;

  // A frame_done colliding with a swap is parked in done_pend and applied the following cycle;
  // OR-ing it with the pending flag makes a second request while parked a no-op.
  assign fd_in    = frame_done & wr_ready;
  assign done_any = fd_in | done_pend;
  assign do_done  = done_any & ~swap_evt;

  // Buffer ownership, back-pressure and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_idx        <= 2'd0;
      draw_idx        <= 2'd1;
      ready_idx       <= 2'd2;
      ready_valid     <= 1'b0;
      done_pend       <= 1'b0;
      wr_ready        <= 1'b1;
      frames_dropped  <= '0;
      frames_repeated <= '0;
    end else begin
      done_pend <= done_any & swap_evt;
      if (swap_evt) begin
        if (ready_valid) begin
          if (NUM_BUFS == 2) begin
            disp_idx <= draw_idx;
            draw_idx <= disp_idx;
            wr_ready <= 1'b1;
          end else begin
            disp_idx <= ready_idx;
          end
          ready_valid <= 1'b0;
        end else if (frames_repeated != '1) begin
          frames_repeated <= frames_repeated + 1'b1;
        end
      end else if (do_done) begin
        ready_valid <= 1'b1;
        if (NUM_BUFS == 3) begin
          ready_idx <= draw_idx;
          draw_idx  <= third_idx;
          if (ready_valid && frames_dropped != '1) begin
            frames_dropped <= frames_dropped + 1'b1;
          end
        end
      end
      // Double-buffered: the draw buffer is frozen as soon as the GPU declares it complete.
      if (NUM_BUFS == 2 && fd_in) begin
        wr_ready <= 1'b0;
      end
    end
  end

  assign wr_en       = wea & wr_ready & ({1'b0, addra} < DEPTH_W);
  assign rd_in_range = {1'b0, addrb} < DEPTH_W;
  assign wr_lin      = MEM_AW'(draw_idx) * MEM_AW'(DEPTH) + MEM_AW'(addra);
  assign rd_lin      = MEM_AW'(disp_idx) * MEM_AW'(DEPTH) + MEM_AW'(addrb);

  // Pixel RAM write port: only the draw buffer is ever written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_lin] <= dina;
    end
  end

  // Scan-out read: address and displayed index are sampled on the same edge, so a swap never mixes buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutb <= '0;
    end else begin
      doutb <= rd_in_range ? mem[rd_lin] : '0;
    end
  end

endmodule

// File: tb/tb_framebuffer_swapchain.sv
module tb_framebuffer_swapchain;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync2, vsync3;
  logic          wea2, wea3;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          frame_done2, frame_done3;
  logic [AW-1:0] addrb;

  logic          wr_ready2, wr_ready3;
  logic [DW-1:0] doutb2, doutb3;
  logic [1:0]    disp2, disp3;
  logic [15:0]   dropped2, repeated2;
  logic [2:0]    dropped3, repeated3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  framebuffer_swapchain #(.ADDR_WIDTH(AW), .DEPTH(DP), .DATA_WIDTH(DW), .NUM_BUFS(2), .CNT_WIDTH(16)) u_dbl (
    .clk(clk), .rst_n(rst_n), .vsync(vsync2), .wea(wea2), .addra(addra), .dina(dina),
    .frame_done(frame_done2), .wr_ready(wr_ready2), .addrb(addrb), .doutb(doutb2),
    .disp_idx(disp2), .frames_dropped(dropped2), .frames_repeated(repeated2)
  );

  framebuffer_swapchain #(.ADDR_WIDTH(AW), .DEPTH(DP), .DATA_WIDTH(DW), .NUM_BUFS(3), .CNT_WIDTH(3)) u_tri (
    .clk(clk), .rst_n(rst_n), .vsync(vsync3), .wea(wea3), .addra(addra), .dina(dina),
    .frame_done(frame_done3), .wr_ready(wr_ready3), .addrb(addrb), .doutb(doutb3),
    .disp_idx(disp3), .frames_dropped(dropped3), .frames_repeated(repeated3)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tab [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input bit tri_sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addra = a;
    dina  = d;
    if (tri_sel) wea3 = 1'b1; else wea2 = 1'b1;
    tick();
    wea2 = 1'b0;
    wea3 = 1'b0;
  endtask

  task automatic done(input bit tri_sel);
    if (tri_sel) frame_done3 = 1'b1; else frame_done2 = 1'b1;
    tick();
    frame_done2 = 1'b0;
    frame_done3 = 1'b0;
  endtask

  task automatic pulse(input bit tri_sel);
    if (tri_sel) vsync3 = 1'b0; else vsync2 = 1'b0;
    repeat (4) tick();
    vsync2 = 1'b1;
    vsync3 = 1'b1;
    repeat (4) tick();
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d2, output logic [DW-1:0] d3);
    addrb = a;
    tick();
    d2 = doutb2;
    d3 = doutb3;
  endtask

  initial begin
    logic [DW-1:0] r2, r3;

    tab[0] = '{addr: 5'd5,  wdat: 8'hA5, exp: 8'hA5};
    tab[1] = '{addr: 5'd0,  wdat: 8'h30, exp: 8'h30};
    tab[2] = '{addr: 5'd1,  wdat: 8'h31, exp: 8'h31};
    tab[3] = '{addr: 5'd7,  wdat: 8'h37, exp: 8'h37};
    tab[4] = '{addr: 5'd15, wdat: 8'h3F, exp: 8'h3F};
    tab[5] = '{addr: 5'd16, wdat: 8'h77, exp: 8'h00};

    rst_n = 1'b0; vsync2 = 1'b1; vsync3 = 1'b1; wea2 = 1'b0; wea3 = 1'b0;
    addra = '0; dina = '0; frame_done2 = 1'b0; frame_done3 = 1'b0; addrb = 5'd3;
    repeat (3) tick();

    // Reset state
    check("rst_doutb2", doutb2, 0);
    check("rst_disp2", disp2, 0);
    check("rst_wr_ready2", wr_ready2, 1);
    check("rst_dropped2", dropped2, 0);
    check("rst_repeated2", repeated2, 0);
    check("rst_doutb3", doutb3, 0);
    check("rst_wr_ready3", wr_ready3, 1);
    check("rst_repeated3", repeated3, 0);
    rst_n = 1'b1;
    tick();
    rd(5'd16, r2, r3);
    check("rd_oob_after_rst2", r2, 0);
    check("rd_oob_after_rst3", r3, 0);

    // Double buffer: fill draw buffer 1 from the table, then complete the frame
    for (int i = 0; i < 6; i++) wr(1'b0, tab[i].addr, tab[i].wdat);
    check("dbl_wr_ready_before_done", wr_ready2, 1);
    done(1'b0);
    check("dbl_wr_ready_after_done", wr_ready2, 0);
    wr(1'b0, 5'd5, 8'hEE);
    wr(1'b0, 5'd7, 8'hEE);
    check("dbl_wr_ready_held", wr_ready2, 0);

    // vsync edge -> swap exactly 3 clk later
    vsync2 = 1'b0;
    tick();
    check("dbl_disp_t1", disp2, 0);
    tick();
    check("dbl_disp_t2", disp2, 0);
    check("dbl_wr_ready_t2", wr_ready2, 0);
    tick();
    check("dbl_disp_t3", disp2, 1);
    check("dbl_wr_ready_t3", wr_ready2, 1);
    repeat (6) tick();
    check("dbl_long_pulse_one_swap", disp2, 1);
    check("dbl_no_repeat_on_long_pulse", repeated2, 0);
    vsync2 = 1'b1;
    repeat (4) tick();

    // Readback of displayed buffer 1: gated and out-of-range writes must not show
    for (int i = 0; i < 6; i++) begin
      rd(tab[i].addr, r2, r3);
      check($sformatf("dbl_readback[%0d]", i), r2, tab[i].exp);
    end

    // Repeat: four edges with nothing ready
    for (int i = 0; i < 4; i++) pulse(1'b0);
    check("dbl_repeat_disp", disp2, 1);
    check("dbl_repeat_count", repeated2, 4);

    // Double buffer collision with nothing ready: swap repeats, frame_done deferred one cycle
    wr(1'b0, 5'd2, 8'h5A);
    vsync2 = 1'b0;
    tick();
    tick();
    frame_done2 = 1'b1;
    tick();
    frame_done2 = 1'b0;
    check("dbl_coll_repeat", repeated2, 5);
    check("dbl_coll_disp", disp2, 1);
    check("dbl_coll_wr_ready", wr_ready2, 0);
    repeat (2) tick();
    vsync2 = 1'b1;
    repeat (4) tick();
    pulse(1'b0);
    check("dbl_coll_next_disp", disp2, 0);
    check("dbl_coll_next_wr_ready", wr_ready2, 1);
    rd(5'd2, r2, r3);
    check("dbl_coll_readback", r2, 8'h5A);

    // Triple buffer: two frames without vsync -> one drop, writer never stalls
    wr(1'b1, 5'd3, 8'h11);
    done(1'b1);
    check("tri_wr_ready_1", wr_ready3, 1);
    check("tri_dropped_0", dropped3, 0);
    wr(1'b1, 5'd3, 8'h22);
    wr(1'b1, 5'd0, 8'h20);
    done(1'b1);
    check("tri_dropped_1", dropped3, 1);
    check("tri_wr_ready_2", wr_ready3, 1);
    pulse(1'b1);
    check("tri_disp_second_frame", disp3, 2);
    rd(5'd3, r2, r3);
    check("tri_read_second_frame", r3, 8'h22);

    // addra == DEPTH into draw buffer 1 would alias onto displayed buffer 2 word 0 if not dropped
    wr(1'b1, 5'd16, 8'h99);
    rd(5'd0, r2, r3);
    check("tri_oob_write_dropped", r3, 8'h20);

    // Triple collision: frame ready, next frame_done lands on swap_evt
    wr(1'b1, 5'd3, 8'h33);
    done(1'b1);
    wr(1'b1, 5'd3, 8'h44);
    vsync3 = 1'b0;
    tick();
    tick();
    frame_done3 = 1'b1;
    tick();
    frame_done3 = 1'b0;
    check("tri_coll_disp_old", disp3, 1);
    tick();
    check("tri_coll_no_drop", dropped3, 1);
    tick();
    vsync3 = 1'b1;
    repeat (4) tick();
    rd(5'd3, r2, r3);
    check("tri_coll_read_old", r3, 8'h33);
    pulse(1'b1);
    check("tri_coll_disp_new", disp3, 0);
    check("tri_coll_no_repeat", repeated3, 0);
    rd(5'd3, r2, r3);
    check("tri_coll_read_new", r3, 8'h44);

    // Repeat counter saturation on the 3-bit instance
    for (int i = 0; i < 4; i++) pulse(1'b1);
    check("tri_repeat_4", repeated3, 4);
    check("tri_repeat_disp", disp3, 0);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    check("tri_repeat_saturate", repeated3, 7);

    // Reset mid-operation with a frame pending
    done(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_disp3", disp3, 0);
    check("midrst_repeated3", repeated3, 0);
    check("midrst_dropped3", dropped3, 0);
    check("midrst_repeated2", repeated2, 0);
    check("midrst_doutb2", doutb2, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse(1'b1);
    check("midrst_pending_discarded_disp", disp3, 0);
    check("midrst_pending_discarded_rep", repeated3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
